// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with programmable almost-full/empty levels and occupancy count.
// Latency: 1-cycle registered read; FIFO_FWFT_EN shows the head word combinationally (no read latency).
// Backpressure: writes when full / reads when empty are dropped and flagged by overflow / underflow.
module fifo_sync_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FIFO_WIDTH-1:0]             data_in,
    input  logic                              wr_en,
    input  logic                              rd_en,
    output logic [FIFO_WIDTH-1:0]             data_out,
    output logic                              wr_ack,
    output logic                              overflow,
    output logic                              underflow,
    output logic                              full,
    output logic                              empty,
    output logic                              almostfull,
    output logic                              almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = !full  && (count >= CNT_W'(AF_LEVEL));
    assign almostempty = !empty && (count <= CNT_W'(AE_LEVEL));

    // Storage has no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Explicit wrap compare so non-power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: fill, drain, wrap, simultaneous ops, reset, thresholds.
// Builds with or without FIFO_FWFT_EN; data_out expectations follow the selected read mode.
module tb_fifo_sync_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        wr_en, rd_en;
    logic [15:0] data_out;
    logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic [3:0]  count;

    logic [15:0] t_data_in;
    logic        t_wr_en, t_rd_en;
    logic [15:0] t_data_out;
    logic        t_wr_ack, t_overflow, t_underflow, t_full, t_empty, t_af, t_ae;
    logic [3:0]  t_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .count(count)
    );

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(5), .AE_LEVEL(3)) u_dut_thr (
        .clk(clk), .rst_n(rst_n), .data_in(t_data_in), .wr_en(t_wr_en), .rd_en(t_rd_en),
        .data_out(t_data_out), .wr_ack(t_wr_ack), .overflow(t_overflow), .underflow(t_underflow),
        .full(t_full), .empty(t_empty), .almostfull(t_af), .almostempty(t_ae),
        .count(t_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [15:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        t_wr_en = 1'b0; t_rd_en = 1'b0; t_data_in = 16'h0;
        cyc(); cyc();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almostfull), 0);
        chk("rst_ae", 32'(almostempty), 0);
        chk("rst_wr_ack", 32'(wr_ack), 0);
        chk("rst_ovf_udf", 32'({overflow, underflow}), 0);
        chk("rst_data_out", 32'(data_out), 0);
        rst_n = 1'b1;
        cyc();

        // Fill: nine writes, the ninth overflows
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 1'b0, 16'(i));
            cyc();
            chk("fill_count", 32'(count), (i <= 8) ? i : 8);
            chk("fill_wr_ack", 32'(wr_ack), (i <= 8) ? 1 : 0);
            chk("fill_overflow", 32'(overflow), (i == 9) ? 1 : 0);
            chk("fill_full", 32'(full), (i >= 8) ? 1 : 0);
            chk("fill_af", 32'(almostfull), (i == 7) ? 1 : 0);
        end
        drive(1'b0, 1'b0, 16'h0);
        cyc();
        chk("fill_ovf_clear", 32'(overflow), 0);
        chk("fill_ack_clear", 32'(wr_ack), 0);

        // Drain: nine reads, the ninth underflows
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b1, 16'h0);
`ifdef FIFO_FWFT_EN
            chk("drain_head", 32'(data_out), (i <= 8) ? i : 0);
            cyc();
`else
            cyc();
            chk("drain_data", 32'(data_out), (i <= 8) ? i : 8);
`endif
            chk("drain_count", 32'(count), (i <= 8) ? 8 - i : 0);
            chk("drain_ae", 32'(almostempty), (i == 7) ? 1 : 0);
            chk("drain_empty", 32'(empty), (i >= 8) ? 1 : 0);
            chk("drain_underflow", 32'(underflow), (i == 9) ? 1 : 0);
        end
        drive(1'b0, 1'b0, 16'h0);
        cyc();
        chk("drain_udf_clear", 32'(underflow), 0);

        // Wrap: pointers start at 0, advance to 6, then run past 7
        for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b0, 16'(16'h10 + i)); cyc(); end
        for (int i = 0; i < 6; i++) begin drive(1'b0, 1'b1, 16'h0); cyc(); end
        drive(1'b0, 1'b0, 16'h0);
        chk("wrap_mid_count", 32'(count), 0);
        for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b0, 16'(16'hA0 + i)); cyc(); end
        chk("wrap_count6", 32'(count), 6);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 16'h0);
`ifdef FIFO_FWFT_EN
            chk("wrap_head", 32'(data_out), 32'(16'hA0 + i));
            cyc();
`else
            cyc();
            chk("wrap_data", 32'(data_out), 32'(16'hA0 + i));
`endif
        end
        drive(1'b0, 1'b0, 16'h0);
        cyc();
        chk("wrap_count0", 32'(count), 0);
        chk("wrap_empty", 32'(empty), 1);

        // Empty with both requests: write only
        drive(1'b1, 1'b1, 16'h55);
        cyc();
        chk("emp_both_count", 32'(count), 1);
        chk("emp_both_udf", 32'(underflow), 1);
        chk("emp_both_ack", 32'(wr_ack), 1);
        for (int i = 1; i <= 3; i++) begin drive(1'b1, 1'b0, 16'(16'h60 + i)); cyc(); end
        chk("mid_pre_count", 32'(count), 4);

        // Mid occupancy with both requests: count holds
        drive(1'b1, 1'b1, 16'h64);
`ifdef FIFO_FWFT_EN
        chk("mid_both_head", 32'(data_out), 32'h55);
        cyc();
`else
        cyc();
        chk("mid_both_data", 32'(data_out), 32'h55);
`endif
        chk("mid_both_count", 32'(count), 4);
        chk("mid_both_ack", 32'(wr_ack), 1);
        chk("mid_both_flags", 32'({overflow, underflow}), 0);
        for (int i = 5; i <= 8; i++) begin drive(1'b1, 1'b0, 16'(16'h60 + i)); cyc(); end
        chk("full_pre", 32'(full), 1);

        // Full with both requests: read only
        drive(1'b1, 1'b1, 16'h69);
`ifdef FIFO_FWFT_EN
        chk("full_both_head", 32'(data_out), 32'h61);
        cyc();
`else
        cyc();
        chk("full_both_data", 32'(data_out), 32'h61);
`endif
        chk("full_both_count", 32'(count), 7);
        chk("full_both_ovf", 32'(overflow), 1);
        chk("full_both_ack", 32'(wr_ack), 0);
        chk("full_both_af", 32'({full, almostfull}), 1);

        // Reset mid-burst at count 5
        drive(1'b0, 1'b1, 16'h0);
        cyc(); cyc();
        drive(1'b1, 1'b1, 16'h70);
        cyc();
        chk("burst_count", 32'(count), 5);
        chk("burst_ack", 32'(wr_ack), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_data_out", 32'(data_out), 0);
        chk("arst_wr_ack", 32'(wr_ack), 0);
        drive(1'b0, 1'b0, 16'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_empty", 32'(empty), 1);

`ifdef FIFO_FWFT_EN
        drive(1'b1, 1'b0, 16'h1234);
        cyc();
        drive(1'b0, 1'b0, 16'h0);
        chk("fwft_show", 32'(data_out), 32'h1234);
        cyc();
        chk("fwft_hold", 32'(data_out), 32'h1234);
`endif

        // Custom thresholds: AF at 5..7, AE at 1..3
        for (int i = 1; i <= 8; i++) begin
            t_wr_en = 1'b1; t_data_in = 16'(i);
            cyc();
            chk("thr_fill_af", 32'(t_af), (i >= 5 && i <= 7) ? 1 : 0);
            chk("thr_fill_ae", 32'(t_ae), (i <= 3) ? 1 : 0);
        end
        t_wr_en = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            t_rd_en = 1'b1;
            cyc();
            chk("thr_drain_count", 32'(t_count), i);
            chk("thr_drain_af", 32'(t_af), (i >= 5 && i <= 7) ? 1 : 0);
            chk("thr_drain_ae", 32'(t_ae), (i >= 1 && i <= 3) ? 1 : 0);
        end
        t_rd_en = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
